golomb_packer: RTL
==================

Name: golomb_packer

Overview:
- Entropy-coding stage directly downstream of the context/error-mapping pipeline.
- Consumes one (MErrval, k) pair per enable pulse and produces the limited-length Golomb-Rice code word (LOCO-I, 8-bit samples).
- Packs the code words MSB-first into 32-bit output words for the byte-stuffing/marker stage.
- A flush input pads the final partial word at end of image.

Parameters:
- LIMIT, 32, maximum code length in bits.
- QBPP, 8, bits per escaped residual.
- ESC_Q, LIMIT-QBPP-1 (=23), unary threshold for escape coding.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low; clears all state.
- en  input  1  symbol valid, one cycle per symbol, may be asserted every cycle.
- k  input  4  Golomb parameter; values >8 are treated as 8.
- MErrval  input  9  mapped error value, sampled when en=1.
- flush  input  1  end-of-image pulse.
- word_out  output  32  packed bitstream word, first bit in bit 31.
- word_valid  output  1  one-cycle strobe, word_out valid.
- flush_done  output  1  one-cycle strobe, flush complete.
- err  output  1  sticky protocol error (en asserted during flush drain).

Behaviour:
- Reset (reset=0, async): word_out=0, word_valid=0, flush_done=0, err=0, accumulator empty, FSM=RUN. Pending bits are discarded.
- Stage 1, registered on the edge where en=1:
  - q = MErrval>>k, computed on the full 9 bits.
  - If q<ESC_Q: code = q zeros, then 1, then MErrval[k-1:0]; len = q+1+k (1..31).
  - Else (escape): code = ESC_Q zeros, then 1, then (MErrval-1)[7:0]; len = 32.
  - flush is registered alongside, so a symbol and a flush in the same cycle are ordered symbol first.
- Stage 2 accumulator: 63-bit shift buffer plus a 6-bit count cnt (0..31 between cycles).
  - Append code below the existing bits.
  - If cnt+len>=32, drive the top 32 bits on word_out with word_valid=1 on the next edge, and keep the cnt+len-32 residual bits.
  - Throughput is one symbol per cycle sustained; the buffer can never overflow.
  - Latency: en at edge t gives the earliest word_valid at edge t+2.
- FSM:
  - RUN: normal operation. A flush arriving in stage 2 is appended to the accumulator (any word it completes is emitted), then the FSM goes to DRAIN.
  - DRAIN (1 cycle): if residual cnt>0, emit the residual left-justified and zero-padded, with word_valid=1. Assert flush_done=1 in the same cycle whether or not a word is emitted. Then clear cnt and return to RUN.
- Protocol and boundary cases:
  - en=1 while in DRAIN, or a second flush before flush_done: the input is dropped and err is set; err stays 1 until reset.
  - flush with cnt=0: no word, flush_done only.
  - k>8: clamped to 8 before the shift.
  - len exactly filling to cnt=32: word emitted, residual 0.
- word_valid and flush_done are single-cycle pulses. word_out holds its last value while word_valid=0.

Test Plan:
1. Plain symbol: k=2, MErrval=9, flush one cycle later -> code "00101" (len 5); DRAIN emits word_out=0x28000000 with word_valid and flush_done in the same cycle.
2. Escape: k=0, MErrval=30 (q=30>=23) -> 32-bit code; word_out=0x0000011D, word_valid at t+2, cnt=0 afterwards.
3. Throughput: 32 back-to-back en cycles with k=0, MErrval=0 (1 bit each) -> exactly one word 0xFFFFFFFF, valid 2 cycles after the 32nd en, then no further words.
4. Straddle: two symbols k=0, MErrval=22 (len 23 each) then flush -> first word 0x00000200; DRAIN word 0x00040000 with flush_done.
5. Reset mid-stream: 20 bits pending, pulse reset low, then flush -> all outputs 0 during reset; flush yields flush_done only, no word_valid.
6. Protocol error: en=1 in the DRAIN cycle -> symbol dropped, err=1 and held until reset; same-cycle en+flush with k=1, MErrval=3 emits 0x60000000 then flush_done, err stays 0.

Source files
------------

// File: rtl/golomb_packer.sv
// Limited-length Golomb-Rice coder (LOCO-I, 8-bit samples) that packs code words
// MSB-first into 32-bit words, with an end-of-image flush that pads the last word.
module golomb_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [3:0]  k,
    input  logic [8:0]  MErrval,
    input  logic        flush,
    output logic [31:0] word_out,
    output logic        word_valid,
    output logic        flush_done,
    output logic        err
);
    localparam int LIMIT = 32;
    localparam int QBPP  = 8;
    localparam int ESC_Q = LIMIT - QBPP - 1;

    typedef enum logic {RUN, DRAIN} state_t;
    state_t state;

    logic        vld_p1;
    logic        flush_p1;
    logic [31:0] code_p1;
    logic [5:0]  len_p1;
    logic [62:0] acc_bits;
    logic [5:0]  cnt;
    logic        blocked;
    logic [62:0] merged;
    logic [5:0]  total;

    // Returns {len, code left-justified in 32 bits}; escape codes are exactly LIMIT bits.
    function automatic logic [37:0] encode(input logic [8:0] merr, input logic [3:0] k_in);
        logic [3:0]  kk;
        logic [8:0]  q;
        logic [8:0]  mask;
        logic [31:0] raw;
        logic [5:0]  len;
        kk   = (k_in > 4'd8) ? 4'd8 : k_in;
        q    = merr >> kk;
        mask = (9'd1 << kk) - 9'd1;
        if (q < 9'(ESC_Q)) begin
            len = 6'(q) + 6'd1 + {2'b00, kk};
            raw = {23'd0, (9'd1 << kk) | (merr & mask)};
            return {len, raw << (6'd32 - len)};
        end
        raw = {23'd0, 1'b1, 8'(merr - 9'd1)};
        return {6'd32, raw};
    endfunction

    // A flush sitting in stage 1 or being drained closes the input until flush_done.
    assign blocked = flush_p1 || (state == DRAIN);

    // ---- stage 1: code construction ----
    always_ff @(posedge clk) begin
        if (en && !blocked)
            {len_p1, code_p1} <= encode(MErrval, k);
    end

    // ---- stage 2: accumulator append ----
    assign merged = vld_p1 ? (acc_bits | ({code_p1, 31'd0} >> cnt)) : acc_bits;
    assign total  = cnt + (vld_p1 ? len_p1 : 6'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            vld_p1     <= 1'b0;
            flush_p1   <= 1'b0;
            acc_bits   <= '0;
            cnt        <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            flush_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            flush_done <= 1'b0;
            vld_p1     <= en && !blocked;
            flush_p1   <= flush && !blocked;
            if (blocked && (en || flush))
                err <= 1'b1;
            case (state)
                RUN: begin
                    if (total >= 6'd32) begin
                        word_out   <= merged[62:31];
                        word_valid <= 1'b1;
                        acc_bits   <= merged << 32;
                        cnt        <= total - 6'd32;
                    end else begin
                        acc_bits <= merged;
                        cnt      <= total;
                    end
                    if (flush_p1)
                        state <= DRAIN;
                end
                DRAIN: begin
                    // Bits below cnt are always zero, so the residual is already padded.
                    if (cnt != 6'd0) begin
                        word_out   <= acc_bits[62:31];
                        word_valid <= 1'b1;
                    end
                    flush_done <= 1'b1;
                    acc_bits   <= '0;
                    cnt        <= '0;
                    state      <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule
